// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the RV32I multicycle control unit.
//   state_e     : 4-bit state encoding (S_FETCH..S_TRAP)
//   OP_*        : RV32I major opcodes recognised by the control unit
//   op_class_e  : opcode classes; bit positions of the one-hot class vector
//   CLASS_OP    : opcode per class, indexed by op_class_e (ILLEGAL excluded)
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL_WB    = 4'd10,
    S_AUIPC     = 4'd11,
    S_JALR_WB   = 4'd12,
    S_I_EXEC    = 4'd13,
    S_LUI       = 4'd14,
    S_TRAP      = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ILLEGAL must stay last: the decoder derives it as "no other class hit".
  typedef enum logic [3:0] {
    C_LOAD    = 4'd0,
    C_STORE   = 4'd1,
    C_RTYPE   = 4'd2,
    C_ITYPE   = 4'd3,
    C_BRANCH  = 4'd4,
    C_JAL     = 4'd5,
    C_JALR    = 4'd6,
    C_AUIPC   = 4'd7,
    C_LUI     = 4'd8,
    C_ILLEGAL = 4'd9
  } op_class_e;

  localparam int NUM_CLASSES = 10;

  localparam logic [6:0] CLASS_OP [NUM_CLASSES-1] = '{
    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
  };

endpackage

// File: rtl/cu_op_decode.sv
// cu_op_decode: combinational opcode classifier.
//   op  in  7            opcode from the instruction register
//   cls out NUM_CLASSES  one-hot class, bit index = op_class_e
// LUI only counts as a legal class when EN_LUI is set; otherwise it lands in ILLEGAL.
module cu_op_decode
  import cu_pkg::*;
#(
  parameter int EN_LUI = 1
) (
  input  logic [6:0]             op,
  output logic [NUM_CLASSES-1:0] cls
);

  logic [NUM_CLASSES-2:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES-1; gi++) begin : g_cls
      if (gi == int'(C_LUI)) begin : g_lui
        assign hit[gi] = (EN_LUI != 0) && (op == CLASS_OP[gi]);
      end else begin : g_std
        assign hit[gi] = (op == CLASS_OP[gi]);
      end
    end
  endgenerate

  assign cls = {~|hit, hit};

endmodule

// File: rtl/cu_fsm.sv
// cu_fsm: registered multicycle control FSM for the RV32I datapath.
//   clk, rst_n          clock, asynchronous active-low reset
//   op                  opcode from the instruction register
//   mem_ready           memory completes the current FETCH/MEM_READ/MEM_WRITE access
//   hold                global stall: freezes state, suppresses strobes
//   trap_ack            releases TRAP back to FETCH
//   state, ns           current (registered) and unstalled next state, zero-extended
//   ir_write, pc_write, mem_req, mem_we, reg_write   datapath strobes
//   illegal             high while in TRAP
//   instr_done          one-cycle pulse when an instruction returns to FETCH
module cu_fsm
  import cu_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter int EN_LUI      = 1,
  parameter int EN_TRAP     = 1,
  parameter int RESET_STATE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  input  logic               hold,
  input  logic               trap_ack,
  output logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] ns,
  output logic               ir_write,
  output logic               pc_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               reg_write,
  output logic               illegal,
  output logic               instr_done
);

  localparam logic [STATE_W-1:0] RST_VAL   = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] FETCH_VAL = STATE_W'(S_FETCH);

  logic [STATE_W-1:0]     state_reg, state_next;
  logic                   instr_done_reg, instr_done_next;
  logic [NUM_CLASSES-1:0] cls;
  state_e                 cur, st_n;
  logic                   cur_valid;
  logic                   active;

  cu_op_decode #(.EN_LUI(EN_LUI)) u_dec (
    .op  (op),
    .cls (cls)
  );

  // Encodings with nonzero upper bits are not states; they recover to FETCH.
  assign cur_valid = ((state_reg >> 4) == '0);
  assign cur       = state_e'(state_reg[3:0]);

  always_comb begin
    st_n = S_FETCH;
    if (cur_valid) begin
      case (cur)
        S_FETCH:     st_n = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (cls[C_LOAD] || cls[C_STORE]) st_n = S_MEM_ADDR;
          else if (cls[C_RTYPE])           st_n = S_R_EXEC;
          else if (cls[C_ITYPE])           st_n = S_I_EXEC;
          else if (cls[C_BRANCH])          st_n = S_BRANCH;
          else if (cls[C_JAL] || cls[C_JALR]) st_n = S_JUMP;
          else if (cls[C_AUIPC])           st_n = S_AUIPC;
          else if (cls[C_LUI])             st_n = S_LUI;
          else if (cls[C_ILLEGAL] && EN_TRAP != 0) st_n = S_TRAP;
          else                             st_n = S_FETCH;
        end
        // op is re-examined here; a class that no longer fits aborts to FETCH.
        S_MEM_ADDR:  st_n = cls[C_STORE] ? S_MEM_WRITE :
                            (cls[C_LOAD] ? S_MEM_READ : S_FETCH);
        S_MEM_READ:  st_n = mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WRITE: st_n = mem_ready ? S_FETCH : S_MEM_WRITE;
        S_R_EXEC, S_I_EXEC, S_AUIPC: st_n = S_ALU_WB;
        S_JUMP:      st_n = cls[C_JAL] ? S_JAL_WB :
                            (cls[C_JALR] ? S_JALR_WB : S_FETCH);
        S_TRAP:      st_n = trap_ack ? S_FETCH : S_TRAP;
        default:     st_n = S_FETCH;
      endcase
    end
  end

  assign state_next = STATE_W'(st_n);

  // The TRAP exit is not a completed instruction.
  assign instr_done_next = (state_next == FETCH_VAL) && (state_reg != FETCH_VAL) &&
                           !hold && !(cur_valid && cur == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RST_VAL;
      instr_done_reg <= 1'b0;
    end else begin
      if (!hold) begin
        state_reg <= state_next;
      end
      instr_done_reg <= instr_done_next;
    end
  end

  // rst_n gates the strobes so they fall as soon as reset asserts, even
  // though the reset state itself (FETCH) would otherwise request memory.
  assign active = rst_n && !hold && cur_valid;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    if (active) begin
      case (cur)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_MEM_READ:  mem_req = 1'b1;
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH:    pc_write = 1'b1;
        S_JAL_WB, S_JALR_WB: begin
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end
        S_MEM_WB, S_ALU_WB, S_LUI: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state      = state_reg;
  assign ns         = state_next;
  assign illegal    = cur_valid && (cur == S_TRAP);
  assign instr_done = instr_done_reg;

endmodule

// File: tb/tb_cu_fsm.sv
module tb_cu_fsm;

  logic       clk = 1'b0;
  logic       rst_n, mem_ready, hold, trap_ack;
  logic [6:0] op;

  logic [3:0] state, ns, state_nt, ns_nt;
  logic       ir_write, pc_write, mem_req, mem_we, reg_write, illegal, instr_done;
  logic       ir_write_nt, pc_write_nt, mem_req_nt, mem_we_nt, reg_write_nt, illegal_nt, instr_done_nt;

  int checks = 0;
  int errors = 0;
  bit exp_done = 1'b0;
  int path_q[$];

  always #5 clk = ~clk;

  cu_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .hold(hold), .trap_ack(trap_ack),
    .state(state), .ns(ns), .ir_write(ir_write), .pc_write(pc_write), .mem_req(mem_req),
    .mem_we(mem_we), .reg_write(reg_write), .illegal(illegal), .instr_done(instr_done)
  );

  cu_fsm #(.EN_TRAP(0), .EN_LUI(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .hold(hold), .trap_ack(trap_ack),
    .state(state_nt), .ns(ns_nt), .ir_write(ir_write_nt), .pc_write(pc_write_nt), .mem_req(mem_req_nt),
    .mem_we(mem_we_nt), .reg_write(reg_write_nt), .illegal(illegal_nt), .instr_done(instr_done_nt)
  );

  wire [6:0] outs = {mem_req, mem_we, ir_write, pc_write, reg_write, illegal, instr_done};

  // Reference: the sequence of states an instruction class walks through.
  task automatic build_path(input logic [6:0] o);
    case (o)
      7'b0000011: path_q = {0, 1, 2, 3, 4};
      7'b0100011: path_q = {0, 1, 2, 5};
      7'b0110011: path_q = {0, 1, 6, 7};
      7'b0010011: path_q = {0, 1, 13, 7};
      7'b0010111: path_q = {0, 1, 11, 7};
      7'b1100011: path_q = {0, 1, 8};
      7'b1101111: path_q = {0, 1, 9, 10};
      7'b1100111: path_q = {0, 1, 9, 12};
      7'b0110111: path_q = {0, 1, 14};
      default:    path_q = {0, 1, 15};
    endcase
  endtask

  // Reference: expected {mem_req, mem_we, ir_write, pc_write, reg_write, illegal, instr_done}.
  function automatic logic [6:0] exp_out(int st, logic mr, logic hd, logic done);
    logic w;
    w = !hd;
    exp_out = {w && (st == 0 || st == 3 || st == 5),
               w && st == 5,
               w && st == 0 && mr,
               w && ((st == 0 && mr) || st == 8 || st == 10 || st == 12),
               w && (st == 4 || st == 7 || st == 10 || st == 12 || st == 14),
               st == 15,
               done};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; hold = 1'b0; trap_ack = 1'b0; op = 7'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_done = 1'b0;
  endtask

  // Runs one instruction from FETCH back to FETCH against the path model.
  task automatic run_instr(input logic [6:0] o, input bit rnd);
    int idx, st, nxt, cyc;
    bit fin, go, nd;
    logic mr, hd, ta;
    idx = 0; fin = 1'b0;
    build_path(o);
    for (cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      mr = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      hd = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      ta = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      op = o; mem_ready = mr; hold = hd; trap_ack = ta;
      #1;
      st  = path_q[idx];
      go  = (st == 0 || st == 3 || st == 5) ? mr : ((st == 15) ? ta : 1'b1);
      nxt = go ? ((idx == path_q.size() - 1) ? 0 : path_q[idx + 1]) : st;
      checks++;
      if (state !== 4'(st) || ns !== 4'(nxt)) begin
        errors++;
        $display("FAIL instr_state op=%b state=%0d ns=%0d expected state=%0d ns=%0d", o, state, ns, st, nxt);
      end
      checks++;
      if (outs !== exp_out(st, mr, hd, exp_done)) begin
        errors++;
        $display("FAIL instr_strobes op=%b state=%0d outs=%b expected %b", o, st, outs, exp_out(st, mr, hd, exp_done));
      end
      nd = go && !hd && (idx == path_q.size() - 1) && st != 15;
      if (go && !hd) begin
        if (idx == path_q.size() - 1) fin = 1'b1;
        else idx++;
      end
      exp_done = nd;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL instr_timeout op=%b stuck at path index %0d", o, idx);
    end
    hold = 1'b0;
    $display("instr op=%b cycles=%0d", o, cyc);
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++;
    if (state !== 4'd0 || outs !== exp_out(0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state state=%0d outs=%b expected state=0 outs=%b", state, outs, exp_out(0, 1'b0, 1'b0, 1'b0));
    end
    op = 7'b0000011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd3 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_read state=%0d mem_req=%b expected 3/1", state, mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || outs !== 7'b0) begin
      errors++;
      $display("FAIL reset_async state=%0d outs=%b expected 0/0000000", state, outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || outs !== exp_out(0, 1'b1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_release state=%0d outs=%b expected 0/%b", state, outs, exp_out(0, 1'b1, 1'b0, 1'b0));
    end
    $display("reset mid MEM_READ done");
  endtask

  task automatic test_sw_wait;
    do_reset;
    op = 7'b0100011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++;
      if (state !== 4'd5 || mem_we !== 1'b1 || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL sw_wait cycle=%0d state=%0d mem_we=%b mem_req=%b expected 5/1/1", i, state, mem_we, mem_req);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (state !== 4'd0 || mem_we !== 1'b0 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL sw_done state=%0d mem_we=%b instr_done=%b expected 0/0/1", state, mem_we, instr_done);
    end
    $display("sw with 3 wait cycles done");
  endtask

  task automatic test_paths;
    do_reset;
    run_instr(7'b0000011, 1'b0);
    run_instr(7'b1100111, 1'b0);
    run_instr(7'b1101111, 1'b0);
    run_instr(7'b0110111, 1'b0);
    run_instr(7'b1100011, 1'b0);
  endtask

  task automatic test_trap;
    do_reset;
    op = 7'b0000000; mem_ready = 1'b1; trap_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd1 || state_nt !== 4'd1) begin
      errors++;
      $display("FAIL trap_decode state=%0d state_nt=%0d expected 1/1", state, state_nt);
    end
    @(negedge clk); #1;
    checks++;
    if (state_nt !== 4'd0 || instr_done_nt !== 1'b1) begin
      errors++;
      $display("FAIL notrap_skip state_nt=%0d instr_done_nt=%b expected 0/1", state_nt, instr_done_nt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 4'd15 || illegal !== 1'b1 || ns !== 4'd15) begin
        errors++;
        $display("FAIL trap_hold cycle=%0d state=%0d illegal=%b ns=%0d expected 15/1/15", i, state, illegal, ns);
      end
      @(negedge clk); #1;
    end
    trap_ack = 1'b1;
    #1;
    checks++;
    if (ns !== 4'd0) begin
      errors++;
      $display("FAIL trap_ack_ns ns=%0d expected 0", ns);
    end
    @(negedge clk); #1;
    trap_ack = 1'b0;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL trap_exit state=%0d illegal=%b instr_done=%b expected 0/0/0", state, illegal, instr_done);
    end
    $display("illegal op trap and skip done");
  endtask

  task automatic test_hold;
    do_reset;
    op = 7'b0110011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state !== 4'd7 || reg_write !== 1'b0 || ns !== 4'd0) begin
        errors++;
        $display("FAIL hold_alu_wb cycle=%0d state=%0d reg_write=%b ns=%0d expected 7/0/0", i, state, reg_write, ns);
      end
      @(negedge clk);
    end
    hold = 1'b0;
    #1;
    checks++;
    if (state !== 4'd7 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL hold_release state=%0d reg_write=%b expected 7/1", state, reg_write);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd0 || reg_write !== 1'b0 || instr_done !== 1'b1) begin
      errors++;
      $display("FAIL hold_done state=%0d reg_write=%b instr_done=%b expected 0/0/1", state, reg_write, instr_done);
    end
    $display("hold in ALU_WB done");
  endtask

  task automatic test_random;
    logic [6:0] ops [10];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b1111111};
    do_reset;
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 5) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      run_instr(o, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; hold = 1'b0; trap_ack = 1'b0; op = 7'd0;
    test_reset;
    test_sw_wait;
    test_paths;
    test_trap;
    test_hold;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
